// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB sequencer with bounded
// memory-wait watchdog and HALT state.
// Optional feature: define MULTICYCLE_PERF_EN to enable the retired-
// instruction counter on instr_retired (otherwise it is tied to zero).
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 8,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrc_a,
  output logic             alusrc_b,
  output logic             extsel,
  output logic [1:0]       aluop,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             branch_ltz,
  output logic             jump,
  output logic [2:0]       state,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  // bltz has no assigned decode; it sits next to beq/bne in the branch group.
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // The watchdog trips on the wait cycle that would bring the count to MAX.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t      state_reg, state_next;
  logic [5:0]  op_q_reg;
  logic [7:0]  wait_cnt_reg;
  logic        mem_err_reg;
  logic        err_trip;
  logic        wait_hit;

  logic        dec_regdst, dec_memtoreg, dec_alusrc_a, dec_alusrc_b, dec_extsel;
  logic [1:0]  dec_aluop;

  assign state   = state_reg;
  assign mem_err = mem_err_reg;
  assign wait_hit = !mem_ready && (wait_cnt_reg == WAIT_LAST);

  // Datapath decode of the latched opcode; anything unlisted is R-type.
  always_comb begin
    dec_aluop    = 2'b10;
    dec_regdst   = 1'b1;
    dec_extsel   = 1'b1;
    dec_memtoreg = 1'b0;
    dec_alusrc_a = 1'b0;
    dec_alusrc_b = 1'b0;
    case (op_q_reg)
      OP_ANDI, OP_ORI: begin
        dec_extsel   = 1'b0;
        dec_regdst   = 1'b0;
        dec_alusrc_b = 1'b1;
      end
      OP_ADDIU: begin
        dec_regdst   = 1'b0;
        dec_alusrc_b = 1'b1;
        dec_aluop    = 2'b00;
      end
      OP_SLTI: begin
        dec_regdst   = 1'b0;
        dec_alusrc_b = 1'b1;
      end
      OP_SLL: begin
        dec_alusrc_a = 1'b1;
      end
      OP_LW: begin
        dec_regdst   = 1'b0;
        dec_memtoreg = 1'b1;
        dec_aluop    = 2'b00;
        dec_alusrc_b = 1'b1;
      end
      OP_SW: begin
        dec_aluop    = 2'b00;
        dec_alusrc_b = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_aluop    = 2'b01;
      end
      default: ;
    endcase
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    state_next = state_reg;
    err_trip   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    regwrite   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    branch_ltz = 1'b0;
    jump       = 1'b0;
    halted     = 1'b0;
    aluop      = 2'b10;
    regdst     = 1'b1;
    extsel     = 1'b1;
    memtoreg   = 1'b0;
    alusrc_a   = 1'b0;
    alusrc_b   = 1'b0;

    // Decode outputs follow op_q only while an instruction is executing.
    if (state_reg == S_EXE || state_reg == S_MEM || state_reg == S_WB) begin
      aluop    = dec_aluop;
      regdst   = dec_regdst;
      extsel   = dec_extsel;
      memtoreg = dec_memtoreg;
      alusrc_a = dec_alusrc_a;
      alusrc_b = dec_alusrc_b;
    end

    case (state_reg)
      S_IF: begin
        memread = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_ID;
        end else if (wait_hit) begin
          err_trip   = 1'b1;
          state_next = S_HALT;
        end
      end
      S_ID: begin
        if (opcode == OP_HALT) begin
          state_next = S_HALT;
        end else if (opcode == OP_J) begin
          pc_write   = 1'b1;
          jump       = 1'b1;
          state_next = S_IF;
        end else begin
          state_next = S_EXE;
        end
      end
      S_EXE: begin
        case (op_q_reg)
          OP_BEQ:       begin branch_eq  = 1'b1; state_next = S_IF; end
          OP_BNE:       begin branch_ne  = 1'b1; state_next = S_IF; end
          OP_BLTZ:      begin branch_ltz = 1'b1; state_next = S_IF; end
          OP_LW, OP_SW: state_next = S_MEM;
          default:      state_next = S_WB;
        endcase
      end
      S_MEM: begin
        iord     = 1'b1;
        memread  = (op_q_reg == OP_LW);
        memwrite = (op_q_reg == OP_SW);
        if (mem_ready) begin
          state_next = (op_q_reg == OP_LW) ? S_WB : S_IF;
        end else if (wait_hit) begin
          err_trip   = 1'b1;
          state_next = S_HALT;
        end
      end
      S_WB: begin
        regwrite   = 1'b1;
        state_next = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_IF;
    endcase
  end

  // State, latched opcode, memory wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IF;
      op_q_reg     <= 6'd0;
      wait_cnt_reg <= 8'd0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_ID) begin
        op_q_reg <= opcode;
      end
      if (state_next != state_reg && (state_next == S_IF || state_next == S_MEM)) begin
        wait_cnt_reg <= 8'd0;
      end else if ((state_reg == S_IF || state_reg == S_MEM) && !mem_ready) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
      if (err_trip) begin
        mem_err_reg <= 1'b1;
      end
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_W-1:0] retired_reg;

  // Count every completed instruction, i.e. each return to IF from ID..WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
    end else if (state_next == S_IF &&
                 (state_reg == S_ID || state_reg == S_EXE ||
                  state_reg == S_MEM || state_reg == S_WB)) begin
      retired_reg <= retired_reg + 1'b1;
    end
  end

  assign instr_retired = retired_reg;
`else
  assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. Each instruction is
// expanded into its expected per-cycle output trace; a monitor checks the
// DUT against that trace every cycle.
module tb_multicycle_control;
  localparam int MAXW = 8;
  localparam int CW   = 4;

  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  logic clk = 1'b0;
  logic rst, mem_ready;
  logic [5:0] opcode;
  logic memread, memwrite, iord, ir_write, pc_write, regwrite, regdst, memtoreg;
  logic alusrc_a, alusrc_b, extsel, branch_eq, branch_ne, branch_ltz, jump;
  logic halted, mem_err;
  logic [1:0] aluop;
  logic [2:0] state;
  logic [CW-1:0] instr_retired;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .extsel(extsel), .aluop(aluop),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .branch_ltz(branch_ltz), .jump(jump),
    .state(state), .halted(halted), .mem_err(mem_err), .instr_retired(instr_retired)
  );

  typedef struct packed {
    logic [2:0]    state;
    logic          memread, memwrite, iord, ir_write, pc_write, regwrite;
    logic          regdst, memtoreg, alusrc_a, alusrc_b, extsel;
    logic [1:0]    aluop;
    logic          branch_eq, branch_ne, branch_ltz, jump, halted, mem_err;
    logic [CW-1:0] retired;
  } out_t;

  out_t act;
  assign act = {state, memread, memwrite, iord, ir_write, pc_write, regwrite,
                regdst, memtoreg, alusrc_a, alusrc_b, extsel, aluop,
                branch_eq, branch_ne, branch_ltz, jump, halted, mem_err, instr_retired};

  out_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  // Reference model state: sticky error flag and completed-instruction count.
  bit merr_m = 1'b0;
  int ret_m  = 0;

  // Baseline outputs for a given state: strobes off, R-type decode defaults.
  function automatic out_t rec(input logic [2:0] st);
    out_t r;
    r = '0;
    r.state   = st;
    r.aluop   = 2'b10;
    r.regdst  = 1'b1;
    r.extsel  = 1'b1;
    r.halted  = (st == 3'd5);
    r.mem_err = merr_m;
    r.retired = ret_m[CW-1:0];
    return r;
  endfunction

  // Decode table for the executing instruction.
  function automatic out_t decoded(input out_t r_in, input logic [5:0] op);
    out_t r;
    r = r_in;
    if (op == OP_ANDI || op == OP_ORI) begin
      r.extsel = 1'b0; r.regdst = 1'b0; r.alusrc_b = 1'b1;
    end else if (op == OP_ADDIU) begin
      r.regdst = 1'b0; r.alusrc_b = 1'b1; r.aluop = 2'b00;
    end else if (op == OP_SLTI) begin
      r.regdst = 1'b0; r.alusrc_b = 1'b1;
    end else if (op == OP_SLL) begin
      r.alusrc_a = 1'b1;
    end else if (op == OP_LW) begin
      r.regdst = 1'b0; r.memtoreg = 1'b1; r.aluop = 2'b00; r.alusrc_b = 1'b1;
    end else if (op == OP_SW) begin
      r.aluop = 2'b00; r.alusrc_b = 1'b1;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      r.aluop = 2'b01;
    end
    return r;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic retire();
`ifdef MULTICYCLE_PERF_EN
    ret_m = (ret_m + 1) % (1 << CW);
`endif
  endtask

  // Apply inputs for one cycle and queue the outputs expected in it.
  task automatic drive(input out_t e, input string nm, input logic rdy,
                       input logic [5:0] opc, input logic r);
    mem_ready = rdy;
    opcode    = opc;
    rst       = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // A memory phase (fetch or data access): w idle cycles then ready, unless
  // the watchdog expires first or reset is asserted at cycle rst_at.
  task automatic wait_phase(input bit in_mem, input logic [5:0] op, input int w,
                            input int rst_at, output bit err, output bit rst_hit);
    out_t e;
    logic [5:0] opc;
    err = 1'b0;
    rst_hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (in_mem) begin
        e = decoded(rec(3'd3), op);
        e.iord = 1'b1;
        e.memread = (op == OP_LW);
        e.memwrite = (op == OP_SW);
        opc = op;
      end else begin
        e = rec(3'd0);
        e.memread = 1'b1;
        opc = 6'($urandom);
      end
      if (i == rst_at) begin
        drive(e, "mem_rst", 1'b1, opc, 1'b1);
        rst_hit = 1'b1;
        return;
      end
      if (i == w) begin
        if (!in_mem) begin
          e.ir_write = 1'b1;
          e.pc_write = 1'b1;
        end
        drive(e, in_mem ? "mem_done" : "if_done", 1'b1, opc, 1'b0);
        return;
      end
      drive(e, in_mem ? "mem_wait" : "if_wait", 1'b0, opc, 1'b0);
      if (i + 1 == MAXW) begin
        err = 1'b1;
        return;
      end
    end
  endtask

  // HALT persists regardless of mem_ready/opcode until reset.
  task automatic halt_phase();
    out_t e;
    repeat (3) begin
      e = rec(3'd5);
      drive(e, "halt", rbit(), 6'($urandom), 1'b0);
    end
    e = rec(3'd5);
    drive(e, "halt_rst", rbit(), 6'($urandom), 1'b1);
    merr_m = 1'b0;
    ret_m  = 0;
  endtask

  task automatic do_instr(input logic [5:0] op, input int w1, input int w2, input int rst_at);
    out_t e;
    bit err, rh;
    wait_phase(1'b0, op, w1, -1, err, rh);
    if (err) begin merr_m = 1'b1; halt_phase(); return; end
    e = rec(3'd1);
    if (op == OP_J) begin e.pc_write = 1'b1; e.jump = 1'b1; end
    drive(e, "id", rbit(), op, 1'b0);
    if (op == OP_HALT) begin halt_phase(); return; end
    if (op == OP_J) begin retire(); return; end
    e = decoded(rec(3'd2), op);
    e.branch_eq  = (op == OP_BEQ);
    e.branch_ne  = (op == OP_BNE);
    e.branch_ltz = (op == OP_BLTZ);
    drive(e, "exe", rbit(), op, 1'b0);
    if (op == OP_BEQ || op == OP_BNE || op == OP_BLTZ) begin retire(); return; end
    if (op == OP_LW || op == OP_SW) begin
      wait_phase(1'b1, op, w2, rst_at, err, rh);
      if (rh) begin merr_m = 1'b0; ret_m = 0; return; end
      if (err) begin merr_m = 1'b1; halt_phase(); return; end
      if (op == OP_SW) begin retire(); return; end
    end
    e = decoded(rec(3'd4), op);
    e.regwrite = 1'b1;
    drive(e, "wb", rbit(), op, 1'b0);
    retire();
  endtask

  // Monitor: compare DUT outputs with the queued expectation mid-cycle.
  out_t  mon_e;
  string mon_nm;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      vectors++;
      if (act !== mon_e) begin
        miscompares++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", mon_nm, cyc, act, mon_e);
      end
    end
  end

  logic [5:0] op_list [11];
  initial begin
    op_list = '{OP_ANDI, OP_ORI, OP_ADDIU, OP_SLTI, OP_SLL, OP_LW, OP_SW,
                OP_BEQ, OP_BNE, OP_BLTZ, OP_J};
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    repeat (2) @(posedge clk);
    #1;

    // Directed sequences.
    do_instr(OP_ADDIU, 0, 0, -1);
    do_instr(OP_LW, 0, 3, -1);
    do_instr(OP_LW, 2, MAXW - 1, -1);
    do_instr(OP_SW, 1, 0, -1);
    do_instr(OP_BEQ, 0, 0, -1);
    do_instr(OP_J, 0, 0, -1);
    do_instr(OP_HALT, 0, 0, -1);
    for (int i = 0; i < 17; i++) do_instr(OP_ADDIU, 0, 0, -1);
    do_instr(OP_LW, 0, 5, 1);
    do_instr(OP_SW, 0, 100, -1);
    do_instr(OP_ORI, MAXW + 2, 0, -1);
    do_instr(OP_SLL, MAXW - 1, 0, -1);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int r, w1, w2, ra;
      r = int'($urandom_range(0, 99));
      if (r < 3)       op = OP_HALT;
      else if (r < 12) op = 6'($urandom);
      else             op = op_list[r % 11];
      w1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
      w2 = int'($urandom_range(0, 9));
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1;
      do_instr(op, w1, w2, ra);
    end

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
